// File: rtl/neuron_seq_ctrl_if.sv
// Scheduler-side port bundle for neuron_seq_ctrl: start/abort/bias request,
// busy status and the valid/ready result channel with its done pulse.
// master = layer scheduler, slave = sequencer.
interface neuron_seq_ctrl_if;
    logic               start;
    logic               abort;
    logic signed [7:0]  bias;
    logic               busy;
    logic signed [16:0] res_data;
    logic               res_valid;
    logic               res_ready;
    logic               done;

    modport master (
        output start, abort, bias, res_ready,
        input  busy, res_data, res_valid, done
    );

    modport slave (
        input  start, abort, bias, res_ready,
        output busy, res_data, res_valid, done
    );
endinterface

// File: rtl/neuron_seq_ctrl.sv
// Sequencer for one neuron datapath (MAC -> bias add -> activation).
// Fetches N_INPUTS {x,w} pairs from a 1-cycle-latency operand memory, streams
// them into the datapath, waits out the pipeline, captures y and offers it on
// a valid/ready port.
// Optional build macro NEURON_SEQ_RELU_EN: clamp negative results to 0 at
// capture. Without it the datapath output is passed through with its sign.
module neuron_seq_ctrl #(
    parameter int N_INPUTS  = 3,
    parameter int ADDR_W    = 4,
    parameter int BASE_ADDR = 0,
    parameter int PIPE_LAT  = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    neuron_seq_ctrl_if.slave    sch,
    output logic                mem_rd_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic [15:0]         mem_rdata_i,
    output logic signed [7:0]   n_x_o,
    output logic signed [7:0]   n_w_o,
    output logic signed [7:0]   n_bias_o,
    output logic                n_acc_clr_o,
    output logic                n_acc_en_o,
    input  logic signed [16:0]  n_y_i
);
    localparam int MAXC = (N_INPUTS > PIPE_LAT) ? N_INPUTS : PIPE_LAT;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0]     LAST_K    = CW'(N_INPUTS - 1);
    localparam logic [CW-1:0]     DRAIN_END = CW'(PIPE_LAT);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_STREAM,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic signed [7:0]   bias_q;
    logic                mem_rd_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                acc_en_q;
    logic                acc_clr_q;
    logic signed [16:0]  res_data_q;
    logic                res_valid_q;

    logic [CW-1:0]       next_k_d;
    logic signed [16:0]  y_cap_d;

    // Next operand index and the result value as it will be captured.
    always_comb begin
        next_k_d = cnt_q + CW'(1);
`ifdef NEURON_SEQ_RELU_EN
        y_cap_d  = n_y_i[16] ? '0 : n_y_i;
`else
        y_cap_d  = n_y_i;
`endif
    end

    // Sequencing FSM. Control outputs are registered so each state's strobes
    // are valid for the whole cycle the state is occupied. DRAIN runs
    // PIPE_LAT+1 cycles: y has settled for a full cycle before capture, which
    // puts res_valid 2+N_INPUTS+PIPE_LAT edges after start is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bias_q      <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            acc_en_q    <= 1'b0;
            acc_clr_q   <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else if (sch.abort && state_q != S_IDLE) begin
            // Abandon everything; nothing partial is ever presented.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            acc_en_q    <= 1'b0;
            acc_clr_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // abort in IDLE still blocks a same-cycle start
                    if (sch.start && !sch.abort) begin
                        state_q    <= S_ISSUE;
                        bias_q     <= sch.bias;
                        cnt_q      <= '0;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= BASE;
                    end
                end
                S_ISSUE: begin
                    state_q    <= S_STREAM;
                    cnt_q      <= '0;
                    acc_en_q   <= 1'b1;
                    acc_clr_q  <= 1'b1;
                    mem_rd_q   <= (LAST_K != '0);
                    mem_addr_q <= (LAST_K != '0) ? BASE + ADDR_W'(1) : '0;
                end
                S_STREAM: begin
                    if (cnt_q == LAST_K) begin
                        state_q    <= S_DRAIN;
                        cnt_q      <= '0;
                        acc_en_q   <= 1'b0;
                        acc_clr_q  <= 1'b0;
                        mem_rd_q   <= 1'b0;
                        mem_addr_q <= '0;
                    end else begin
                        // prefetch the pair for k+1 while k is consumed
                        cnt_q      <= next_k_d;
                        acc_clr_q  <= 1'b0;
                        mem_rd_q   <= (next_k_d != LAST_K);
                        mem_addr_q <= (next_k_d != LAST_K)
                                      ? BASE + ADDR_W'(next_k_d) + ADDR_W'(1) : '0;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == DRAIN_END) begin
                        state_q     <= S_HOLD;
                        cnt_q       <= '0;
                        res_data_q  <= y_cap_d;
                        res_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (sch.res_ready) begin
                        state_q     <= S_IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Operands come straight from memory data while a pair is being consumed,
    // forced to zero otherwise.
    assign n_x_o       = acc_en_q ? mem_rdata_i[15:8] : '0;
    assign n_w_o       = acc_en_q ? mem_rdata_i[7:0]  : '0;
    assign n_bias_o    = bias_q;
    assign n_acc_en_o  = acc_en_q;
    assign n_acc_clr_o = acc_clr_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_addr_o  = mem_addr_q;

    assign sch.busy      = (state_q != S_IDLE);
    assign sch.res_data  = res_data_q;
    assign sch.res_valid = res_valid_q;
    // done marks the handshake cycle itself; abort suppresses it.
    assign sch.done      = (state_q == S_HOLD) && sch.res_ready && !sch.abort;
endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Bench for neuron_seq_ctrl: operand memory and 3-stage datapath models,
// directed scenarios, scoreboard queue checked by a negedge monitor.
module tb_neuron_seq_ctrl;
    localparam int N  = 3;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    neuron_seq_ctrl_if sif();

    logic               mem_rd;
    logic [AW-1:0]      mem_addr;
    logic [15:0]        mem_rdata;
    logic signed [7:0]  n_x, n_w, n_bias;
    logic               n_acc_clr, n_acc_en;
    logic signed [16:0] n_y;

    neuron_seq_ctrl #(.N_INPUTS(N), .ADDR_W(AW), .BASE_ADDR(0), .PIPE_LAT(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sch(sif),
        .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
        .n_x_o(n_x), .n_w_o(n_w), .n_bias_o(n_bias),
        .n_acc_clr_o(n_acc_clr), .n_acc_en_o(n_acc_en), .n_y_i(n_y)
    );

    // operand memory, 1-cycle read latency
    logic [15:0] mem [16];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    // datapath: accumulate, add bias, activation (identity)
    logic signed [16:0] prod, bias_x, acc, s2;
    assign prod   = n_x * n_w;
    assign bias_x = n_bias;
    always @(posedge clk) begin
        if (n_acc_en) acc <= n_acc_clr ? prod : acc + prod;
        s2  <= acc + bias_x;
        n_y <= s2;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_done = 0;
    int exp_done = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [16:0] data;
        int                 due;
    } exp_t;
    exp_t sb[$];
    logic [AW-1:0] addr_log[$];
    logic vld_prev;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // monitor: latency on rising valid, data every valid cycle, pop on done
    always @(negedge clk) begin
        if (!rst_n) begin
            vld_prev <= 1'b0;
        end else begin
            if (sif.res_valid && !vld_prev) begin
                if (sb.size() == 0) chk("unexpected_valid", 1, 0);
                else                chk("latency", cyc, sb[0].due);
            end
            if (sif.res_valid && sb.size() > 0) chk("res_data", sif.res_data, sb[0].data);
            if (sif.done) begin
                n_done <= n_done + 1;
                chk("done_with_valid", sif.res_valid, 1);
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (mem_rd) addr_log.push_back(mem_addr);
            vld_prev <= sif.res_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic signed [7:0] x0, w0, x1, w1, x2, w2);
        mem[0] = {x0, w0};
        mem[1] = {x1, w1};
        mem[2] = {x2, w2};
    endtask

    task automatic launch(input logic signed [7:0] b, input bit push, input logic signed [16:0] exp);
        sif.bias  = b;
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        chk("start_accepted_busy", sif.busy, 1);
        if (push) sb.push_back('{data: exp, due: cyc + 8});
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sif.busy && n < budget) begin tick(); n++; end
        chk("wait_idle_timeout", sif.busy, 0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!sif.res_valid && n < budget) begin tick(); n++; end
        chk("wait_valid_timeout", sif.res_valid, 1);
    endtask

    task automatic chk_addrs();
        chk("addr_count", addr_log.size(), 3);
        for (int i = 0; i < 3 && i < addr_log.size(); i++) chk("addr_seq", addr_log[i], i);
    endtask

    task automatic chk_reset(input string nm);
        chk(nm, {sif.busy, mem_rd, mem_addr, n_x, n_w, n_bias, n_acc_clr, n_acc_en,
                 sif.res_data, sif.res_valid, sif.done}, 0);
    endtask

    localparam logic signed [16:0] NEG_EXP =
`ifdef NEURON_SEQ_RELU_EN
        17'sd0;
`else
        -17'sd53;
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        sif.start = 0; sif.abort = 0; sif.bias = 0; sif.res_ready = 0;
        #2 rst_n = 1'b0;
        #1 chk_reset("reset_outputs");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: basic evaluation, consumer always ready
        load(1, 4, 2, 5, 3, 6);
        sif.res_ready = 1'b1;
        addr_log.delete();
        launch(10, 1, 42);
        exp_done++;
        wait_idle(20);
        chk_addrs();

        // 2: back-to-back start, consumer stalls 5 cycles
        sif.res_ready = 1'b0;
        launch(10, 1, 42);
        exp_done++;
        wait_valid(20);
        repeat (5) tick();
        chk("hold_valid_stable", sif.res_valid, 1);
        sif.res_ready = 1'b1;
        wait_idle(5);

        // 3: negative result
        load(-5, 10, 0, 0, 0, 0);
        launch(-3, 1, NEG_EXP);
        exp_done++;
        wait_idle(20);

        // 4: abort during STREAM at k=1, then a clean run
        load(1, 4, 2, 5, 3, 6);
        launch(10, 0, 0);
        tick(); tick();
        chk("k1_en_clr", {n_acc_en, n_acc_clr}, 2'b10);
        sif.abort = 1'b1;
        tick();
        sif.abort = 1'b0;
        chk("abort_idle", {sif.busy, mem_rd, n_acc_en, sif.res_valid}, 0);
        repeat (10) tick();
        launch(10, 1, 42);
        exp_done++;
        wait_idle(20);

        // 4b: abort beats res_ready in HOLD
        sif.res_ready = 1'b0;
        launch(10, 1, 42);
        wait_valid(20);
        sif.abort = 1'b1;
        sif.res_ready = 1'b1;
        #1 chk("abort_beats_ready", sif.done, 0);
        tick();
        sif.abort = 1'b0;
        sif.res_ready = 1'b0;
        chk("abort_hold_idle", {sif.busy, sif.res_valid}, 0);
        void'(sb.pop_front());

        // 5: start pulses while busy are ignored
        addr_log.delete();
        launch(10, 1, 42);
        exp_done++;
        tick();
        sif.start = 1'b1; tick(); sif.start = 1'b0;
        wait_valid(20);
        sif.start = 1'b1; tick(); sif.start = 1'b0;
        sif.res_ready = 1'b1;
        tick();
        sif.res_ready = 1'b0;
        tick(); tick();
        chk("start_not_queued", sif.busy, 0);
        chk_addrs();

        // 6: reset in DRAIN, then a full-latency run
        sif.res_ready = 1'b1;
        launch(10, 0, 0);
        repeat (5) tick();
        chk("in_drain", {sif.busy, n_acc_en, mem_rd}, 3'b100);
        rst_n = 1'b0;
        #1 chk_reset("reset_in_drain");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        launch(10, 1, 42);
        exp_done++;
        wait_idle(20);

        tick(); tick();
        chk("done_count", n_done, exp_done);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
